// File: rtl/nor_multi_bus.sv
// nor_multi_bus: pipelined Wishbone to parallel NOR bridge for NCHIPS devices that share
// addr/data/oe/we, with one active-low CE per chip. Setup/pulse/hold timing comes from cfg_*_i
// and is latched per access. Requests queue in a DEPTH-entry FIFO; responses return in order.
// Optional feature macro: NOR_BUS_RY_TIMEOUT_EN (bounded ready-wait, error on expiry).
module nor_multi_bus #(
    parameter int unsigned ADDRBITS   = 26,
    parameter int unsigned DATABITS   = 16,
    parameter int unsigned NCHIPS     = 2,
    parameter int unsigned DEPTH      = 16,
    parameter int unsigned CNTBITS    = 8,
    parameter int unsigned RY_TIMEOUT = 4096,
    localparam int unsigned CSBITS    = (NCHIPS > 1) ? $clog2(NCHIPS) : 1
) (
    input  logic                       wb_clk_i,
    input  logic                       wb_rst_i,
    input  logic [CSBITS+ADDRBITS-1:0] wb_adr_i,
    input  logic [DATABITS-1:0]        wb_dat_i,
    input  logic                       wb_we_i,
    input  logic                       wb_stb_i,
    input  logic                       wb_cyc_i,
    output logic                       wb_stall_o,
    output logic                       wb_ack_o,
    output logic                       wb_err_o,
    output logic [DATABITS-1:0]        wb_dat_o,
    input  logic [CNTBITS-1:0]         cfg_setup_i,
    input  logic [CNTBITS-1:0]         cfg_pulse_i,
    input  logic [CNTBITS-1:0]         cfg_hold_i,
    input  logic [NCHIPS-1:0]          nor_ry_i,
    input  logic [DATABITS-1:0]        nor_data_i,
    output logic [DATABITS-1:0]        nor_data_o,
    output logic [ADDRBITS-1:0]        nor_addr_o,
    output logic [NCHIPS-1:0]          nor_ce_o,
    output logic                       nor_we_o,
    output logic                       nor_oe_o,
    output logic                       nor_data_oe
);

    localparam int unsigned ABITS = CSBITS + ADDRBITS;
    localparam int unsigned EBITS = 1 + DATABITS + ABITS;
    localparam int unsigned PBITS = $clog2(DEPTH);
    localparam int unsigned QBITS = $clog2(DEPTH + 1);
    localparam logic [QBITS-1:0] FULL_COUNT = QBITS'(DEPTH);

    typedef enum logic [2:0] {StIdle, StRdyWait, StSetup, StPulse, StHold} state_e;

    // Request FIFO
    logic [EBITS-1:0]    fifo_mem [DEPTH];
    logic [PBITS-1:0]    wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [QBITS-1:0]    count_q, count_d;
    logic                stall_q;
    logic                push, pop;
    logic                head_we;
    logic [DATABITS-1:0] head_dat;
    logic [CSBITS-1:0]   head_chip;
    logic [ADDRBITS-1:0] head_addr;
    logic                head_valid, head_ry, req_ry;

    // Access state
    state_e              state_q, state_d;
    logic [CNTBITS-1:0]  cnt_q, cnt_d;
    logic [CNTBITS-1:0]  pulse_q, hold_q, setup_q;
    logic                req_we_q, req_we_d;
    logic [CSBITS-1:0]   req_chip_q, req_chip_d;
    logic [ADDRBITS-1:0] req_addr_q;
    logic [DATABITS-1:0] req_dat_q;
    logic                load_req, sample_rd;
    logic                no_ack_q, no_ack_d;
    logic [DATABITS-1:0] rdata_q;

    // Registered outputs
    logic                ack_q, ack_d, err_q, err_d;
    logic [DATABITS-1:0] dat_o_q;
    logic [NCHIPS-1:0]   ce_q, ce_d;
    logic                we_q, we_d, oe_q, oe_d, doe_q, doe_d;

`ifdef NOR_BUS_RY_TIMEOUT_EN
    localparam int unsigned RYBITS = $clog2(RY_TIMEOUT + 1);
    logic [RYBITS-1:0] ry_cnt_q, ry_cnt_d;
`else
    logic unused_ry_timeout;
    assign unused_ry_timeout = ^RY_TIMEOUT;
`endif

    assign push = wb_cyc_i & wb_stb_i & ~stall_q;
    assign {head_we, head_dat, head_chip, head_addr} = fifo_mem[rd_ptr_q];
    assign head_valid = 32'(head_chip) < NCHIPS;

    // Ready lookup for the FIFO head and for the latched request
    always_comb begin
        head_ry = 1'b0;
        req_ry  = 1'b0;
        for (int unsigned i = 0; i < NCHIPS; i++) begin
            if (head_chip == CSBITS'(i)) head_ry = nor_ry_i[i];
            if (req_chip_q == CSBITS'(i)) req_ry = nor_ry_i[i];
        end
    end

    // FIFO pointer/occupancy next state; cyc low flushes everything
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (!wb_cyc_i) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (push) wr_ptr_d = wr_ptr_q + 1'b1;
            if (pop)  rd_ptr_d = rd_ptr_q + 1'b1;
            if (push && !pop)      count_d = count_q + 1'b1;
            else if (!push && pop) count_d = count_q - 1'b1;
        end
    end

    // FIFO storage, no reset needed
    always_ff @(posedge wb_clk_i) begin
        if (push) fifo_mem[wr_ptr_q] <= {wb_we_i, wb_dat_i, wb_adr_i};
    end

    // Access FSM next-state
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        pop       = 1'b0;
        load_req  = 1'b0;
        sample_rd = 1'b0;
        no_ack_d  = no_ack_q;
        ack_d     = 1'b0;
        err_d     = 1'b0;
`ifdef NOR_BUS_RY_TIMEOUT_EN
        ry_cnt_d  = ry_cnt_q;
`endif
        // A started strobe sequence always completes; a cyc drop only suppresses its ack.
        if (!wb_cyc_i && (state_q inside {StSetup, StPulse, StHold})) no_ack_d = 1'b1;
        unique case (state_q)
            StIdle: begin
                if (wb_cyc_i && count_q != '0) begin
                    pop      = 1'b1;
                    no_ack_d = 1'b0;
                    if (!head_valid) begin
                        err_d = 1'b1;
                    end else begin
                        load_req = 1'b1;
                        // Ready already high skips the wait state entirely.
                        if (head_we && !head_ry) begin
                            state_d = StRdyWait;
`ifdef NOR_BUS_RY_TIMEOUT_EN
                            ry_cnt_d = '0;
`endif
                        end else begin
                            state_d = StSetup;
                            cnt_d   = cfg_setup_i;
                        end
                    end
                end
            end
            StRdyWait: begin
                if (!wb_cyc_i) begin
                    state_d = StIdle;
                end else if (req_ry) begin
                    state_d = StSetup;
                    cnt_d   = setup_q;
`ifdef NOR_BUS_RY_TIMEOUT_EN
                end else if (ry_cnt_q == RYBITS'(RY_TIMEOUT - 1)) begin
                    state_d = StIdle;
                    err_d   = 1'b1;
                end else begin
                    ry_cnt_d = ry_cnt_q + 1'b1;
`endif
                end
            end
            StSetup: begin
                if (cnt_q == '0) begin
                    state_d = StPulse;
                    cnt_d   = pulse_q;
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            StPulse: begin
                if (cnt_q == '0) begin
                    state_d   = StHold;
                    cnt_d     = hold_q;
                    sample_rd = !req_we_q;
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            StHold: begin
                if (cnt_q == '0) begin
                    state_d = StIdle;
                    ack_d   = !no_ack_q && wb_cyc_i;
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    assign req_we_d   = load_req ? head_we : req_we_q;
    assign req_chip_d = load_req ? head_chip : req_chip_q;

    // NOR strobe next values, decoded from the next state so the pins are registered
    always_comb begin
        ce_d = '1;
        for (int unsigned i = 0; i < NCHIPS; i++) begin
            if ((state_d == StSetup || state_d == StPulse) && req_chip_d == CSBITS'(i)) begin
                ce_d[i] = 1'b0;
            end
        end
        we_d  = ~(state_d == StPulse && req_we_d);
        oe_d  = ~(state_d == StPulse && !req_we_d);
        doe_d = req_we_d && (state_d inside {StSetup, StPulse, StHold});
    end

    // State and output registers
    always_ff @(posedge wb_clk_i) begin
        if (wb_rst_i) begin
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            count_q    <= '0;
            stall_q    <= 1'b0;
            state_q    <= StIdle;
            cnt_q      <= '0;
            setup_q    <= '0;
            pulse_q    <= '0;
            hold_q     <= '0;
            req_we_q   <= 1'b0;
            req_chip_q <= '0;
            req_addr_q <= '0;
            req_dat_q  <= '0;
            no_ack_q   <= 1'b0;
            rdata_q    <= '0;
            ack_q      <= 1'b0;
            err_q      <= 1'b0;
            dat_o_q    <= '0;
            ce_q       <= '1;
            we_q       <= 1'b1;
            oe_q       <= 1'b1;
            doe_q      <= 1'b0;
`ifdef NOR_BUS_RY_TIMEOUT_EN
            ry_cnt_q   <= '0;
`endif
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            stall_q  <= (count_d == FULL_COUNT);
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            no_ack_q <= no_ack_d;
            ack_q    <= ack_d;
            err_q    <= err_d;
            ce_q     <= ce_d;
            we_q     <= we_d;
            oe_q     <= oe_d;
            doe_q    <= doe_d;
`ifdef NOR_BUS_RY_TIMEOUT_EN
            ry_cnt_q <= ry_cnt_d;
`endif
            if (load_req) begin
                req_we_q   <= head_we;
                req_chip_q <= head_chip;
                req_addr_q <= head_addr;
                req_dat_q  <= head_dat;
                setup_q    <= cfg_setup_i;
                pulse_q    <= cfg_pulse_i;
                hold_q     <= cfg_hold_i;
            end
            if (sample_rd) rdata_q <= nor_data_i;
            if (ack_d && !req_we_q) dat_o_q <= rdata_q;
        end
    end

    assign wb_stall_o  = stall_q;
    assign wb_ack_o    = ack_q;
    assign wb_err_o    = err_q;
    assign wb_dat_o    = dat_o_q;
    assign nor_ce_o    = ce_q;
    assign nor_we_o    = we_q;
    assign nor_oe_o    = oe_q;
    assign nor_data_oe = doe_q;
    assign nor_addr_o  = req_addr_q;
    assign nor_data_o  = req_dat_q;

endmodule
